arbitro_memoria_datos: RTL
==========================

# arbitro_memoria_datos

Two-port arbiter and access sequencer in front of the single-port data memory (`memoria_datos`). It lets the processor datapath (port 0) and a loader/debug master (port 1) share the memory. Each transaction is latched, driven onto the memory's `EscrMem`/`LeerMem`/`Direc`/`Datain` for exactly one cycle, and completed with a per-port acknowledge carrying read data. Arbitration is two-way round-robin; one transaction completes every 3 cycles.

## Interface

Parameters:
- `ANCHO_DIR`, default 8: memory address width.
- `ANCHO_DATO`, default 32: data width.

Ports (the clock is `clk`; reset `rst` is asynchronous, active-high):
- `clk`  in  1  single clock; all state changes on its rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `req0`, `req1`  in  1  access request, port 0 / port 1.
- `we0`, `we1`  in  1  1 = write, 0 = read; sampled together with req.
- `dir0`, `dir1`  in  ANCHO_DIR  address; sampled together with req.
- `din0`, `din1`  in  ANCHO_DATO  write data; sampled together with req.
- `gnt0`, `gnt1`  out  1  one-cycle pulse: request accepted.
- `ack0`, `ack1`  out  1  one-cycle pulse: transaction complete.
- `dout`  out  ANCHO_DATO  read data; valid only while ack0 or ack1 is high for a read.
- `EscrMem`  out  1  memory write strobe.
- `LeerMem`  out  1  memory read strobe.
- `Direc`  out  ANCHO_DIR  memory address.
- `Datain`  out  ANCHO_DATO  memory write data.
- `Dataout`  in  ANCHO_DATO  memory registered read data.

## Operation

- States:
  - `INACTIVO`: waits for a request.
  - `ACCESO`: drives the memory command.
  - `RESPUESTA`: issues ack and read data.
- `INACTIVO` → `ACCESO`, on any sampled req:
  - Latch `we`/`dir`/`din` of the winner into internal registers.
  - Record the winner's port index.
  - Update the round-robin pointer to the port that was *not* served.
- Arbitration:
  - Only one req high: that port wins.
  - Both high: the port named by the pointer wins.
  - Pointer resets to port 0.
- `ACCESO` → `RESPUESTA`, unconditionally.
  - `EscrMem` = latched we, `LeerMem` = not latched we.
  - `Direc`/`Datain` = latched values.
  - `gnt` of the winner is high this cycle only.
- `RESPUESTA` → `INACTIVO`, unconditionally.
  - `ack` of the winner is high; `dout` = `Dataout`.
  - For writes, `dout` is don't-care but must equal `Dataout`. No extra muxing.
- Requests are ignored in `ACCESO` and `RESPUESTA`.
- A requester drops req on the edge after it sees gnt. A req still high in `INACTIVO` is a new transaction.
- `EscrMem` and `LeerMem` are never both high, and are both low outside `ACCESO`.
- `Direc`/`Datain` hold their last latched values between transactions. No glitching to zero.

## Timing

- Reset values, applied immediately on `rst` rise:
  - State `INACTIVO`, pointer 0.
  - `gnt0`/`gnt1`/`ack0`/`ack1` = 0.
  - `EscrMem` = `LeerMem` = 0.
  - `Direc` = 0, `Datain` = 0, latched registers 0.
- Cycle sequence: req sampled high at edge E0 → gnt high in cycle E0..E1 → memory captures at E1 → ack high in cycle E1..E2 → `INACTIVO` after E2.
- Latency from req sample to ack: 2 edges. Back-to-back throughput: 1 transaction per 3 cycles.
- All memory command outputs are registered (or decoded only from state plus latched registers). No combinational path from req* to memory pins.
- Both ports request at every `INACTIVO`: grants alternate 0,1,0,1…; neither port waits more than one transaction.
- Reset asserted in `ACCESO`: strobes drop asynchronously. Whether the memory wrote depends on whether the edge preceded `rst`; no ack is ever issued for that transaction.
- Reset asserted in `RESPUESTA`: ack drops at once; the requester must reissue.
- Address wrap: none. `dir` is passed through unmodified; 0xFF is a legal address.

## Structure

- Shared package: `ANCHO_DIR`/`ANCHO_DATO` defaults and state encoding constants (`INACTIVO`=2'd0, `ACCESO`=2'd1, `RESPUESTA`=2'd2; 2'd3 recovers to `INACTIVO`).
- One sub-module `selector_rr`: inputs req0/req1 and the pointer; outputs a one-hot winner. It is purely combinational; the pointer register stays in the parent.
- The FSM, latches and output decode live in `arbitro_memoria_datos`.

## Test plan

- Port 0 write: `req0`=1, `we0`=1, `dir0`=0x10, `din0`=0xDEADBEEF.
  - Cycle 1: `gnt0`, `EscrMem`=1, `Direc`=0x10, `Datain`=0xDEADBEEF.
  - Cycle 2: `ack0`=1. No activity on port 1 signals.
- Port 1 read of 0x10 after the above: `LeerMem`=1 in `ACCESO`; `ack1`=1 with `dout`=0xDEADBEEF in `RESPUESTA`.
- Simultaneous req0/req1 held high for 4 transactions after reset: grant order 0,1,0,1, each 3 cycles apart. `EscrMem`&`LeerMem` never both 1.
- Req held high after gnt: a second identical transaction starts at the next `INACTIVO` sample; 2 acks total.
- `rst` pulsed mid-`ACCESO` of a write to 0x20: `EscrMem` falls the same time step; no ack; state `INACTIVO`; pointer 0; `Direc`=0.
- Address boundary: write 0x12345678 to 0xFF, then read 0xFF and 0x00. The read returns 0x12345678 only at 0xFF.

Source files
------------

// File: rtl/arbitro_memoria_datos_pkg.sv
// rtl/arbitro_memoria_datos_pkg.sv - shared widths, state encoding and helpers for the data-memory arbiter
package arbitro_memoria_datos_pkg;

  localparam int ANCHO_DIR_DEF  = 8;
  localparam int ANCHO_DATO_DEF = 32;

  // Sequencer states; the unused code 2'd3 falls back to INACTIVO
  localparam logic [1:0] INACTIVO  = 2'd0;
  localparam logic [1:0] ACCESO    = 2'd1;
  localparam logic [1:0] RESPUESTA = 2'd2;

  // One-hot winner as produced by the selector: bit 0 = port 0, bit 1 = port 1
  typedef logic [1:0] ganador_t;

  // Port index of a one-hot winner (port 1 only when bit 1 is set)
  function automatic logic indice_ganador(input ganador_t g);
    return g[1];
  endfunction

endpackage

// File: rtl/arbitro_memoria_datos_selector_rr.sv
// rtl/arbitro_memoria_datos_selector_rr.sv - combinational two-way round-robin winner select
module selector_rr
  import arbitro_memoria_datos_pkg::*;
(
  input  logic     req0,
  input  logic     req1,
  input  logic     ptr,
  output ganador_t ganador
);

  // A lone requester always wins; on contention the pointer names the winner
  always_comb begin
    ganador = 2'b00;
    if (req0 && req1) begin
      ganador = ptr ? 2'b10 : 2'b01;
    end else if (req0) begin
      ganador = 2'b01;
    end else if (req1) begin
      ganador = 2'b10;
    end
  end

endmodule

// File: rtl/arbitro_memoria_datos.sv
// rtl/arbitro_memoria_datos.sv - two-port round-robin arbiter and access sequencer for the data memory
module arbitro_memoria_datos
  import arbitro_memoria_datos_pkg::*;
#(
  parameter int ANCHO_DIR  = ANCHO_DIR_DEF,
  parameter int ANCHO_DATO = ANCHO_DATO_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req0,
  input  logic                  req1,
  input  logic                  we0,
  input  logic                  we1,
  input  logic [ANCHO_DIR-1:0]  dir0,
  input  logic [ANCHO_DIR-1:0]  dir1,
  input  logic [ANCHO_DATO-1:0] din0,
  input  logic [ANCHO_DATO-1:0] din1,
  output logic                  gnt0,
  output logic                  gnt1,
  output logic                  ack0,
  output logic                  ack1,
  output logic [ANCHO_DATO-1:0] dout,
  output logic                  EscrMem,
  output logic                  LeerMem,
  output logic [ANCHO_DIR-1:0]  Direc,
  output logic [ANCHO_DATO-1:0] Datain,
  input  logic [ANCHO_DATO-1:0] Dataout
);

  logic [1:0]            state_d, state_q;
  logic                  ptr_d,   ptr_q;
  logic                  sel_d,   sel_q;
  logic                  we_d,    we_q;
  logic [ANCHO_DIR-1:0]  dir_d,   dir_q;
  logic [ANCHO_DATO-1:0] din_d,   din_q;

  ganador_t ganador;
  logic     en_acceso;
  logic     en_respuesta;

  selector_rr u_selector_rr (
    .req0    (req0),
    .req1    (req1),
    .ptr     (ptr_q),
    .ganador (ganador)
  );

  // Next-state logic: requests are only looked at in INACTIVO, where the winner's command is latched
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    sel_d   = sel_q;
    we_d    = we_q;
    dir_d   = dir_q;
    din_d   = din_q;
    case (state_q)
      INACTIVO: begin
        if (ganador != 2'b00) begin
          state_d = ACCESO;
          sel_d   = indice_ganador(ganador);
          // Pointer moves to the port that was not served this time
          ptr_d   = ~indice_ganador(ganador);
          if (indice_ganador(ganador)) begin
            we_d  = we1;
            dir_d = dir1;
            din_d = din1;
          end else begin
            we_d  = we0;
            dir_d = dir0;
            din_d = din0;
          end
        end
      end
      ACCESO:    state_d = RESPUESTA;
      RESPUESTA: state_d = INACTIVO;
      default:   state_d = INACTIVO;
    endcase
  end

  // State and latched command registers; reset clears everything immediately
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= INACTIVO;
      ptr_q   <= 1'b0;
      sel_q   <= 1'b0;
      we_q    <= 1'b0;
      dir_q   <= '0;
      din_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      sel_q   <= sel_d;
      we_q    <= we_d;
      dir_q   <= dir_d;
      din_q   <= din_d;
    end
  end

  // Output decode uses only state and latched registers, so req* never reaches the memory pins
  always_comb begin
    en_acceso    = (state_q == ACCESO);
    en_respuesta = (state_q == RESPUESTA);
    gnt0         = en_acceso & ~sel_q;
    gnt1         = en_acceso &  sel_q;
    ack0         = en_respuesta & ~sel_q;
    ack1         = en_respuesta &  sel_q;
    EscrMem      = en_acceso &  we_q;
    LeerMem      = en_acceso & ~we_q;
    Direc        = dir_q;
    Datain       = din_q;
    dout         = Dataout;
  end

endmodule
